// File: rtl/spi_4094_master.sv
// SPI master for the 74HC4094 chain: shifts a word out MSB first, strobes it to the
// chain outputs and captures the word shifted out of the chain's last stage.
//
// state  | meaning
// IDLE   | waiting for i_start, bus parked low
// LO     | SCK low half-period, MOSI presents tx MSB
// HI     | SCK high half-period, rx captured on entry
// STROBE | one settle cycle after the last SCK fall, then STROBE high for CLK_DIV cycles
// DONE   | o_done pulse with o_data valid; a new i_start is accepted here
module spi_4094_master #(
   parameter int NBITS   = 32,
   parameter int CLK_DIV = 4
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             i_start,
   input  logic [NBITS-1:0] i_data,
   output logic             o_busy,
   output logic             o_done,
   output logic [NBITS-1:0] o_data,
   output logic             o_4094_clk,
   output logic             o_4094_data,
   output logic             o_4094_strobe,
   input  logic             i_4094_miso
);

   localparam int CW = $clog2(NBITS + 1);
   localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [CW-1:0] CNT_LOAD = CW'(NBITS);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [DW-1:0] DIV_LOAD = DW'(CLK_DIV - 1);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LO     = 3'd1,
      HI     = 3'd2,
      STROBE = 3'd3,
      DONE   = 3'd4
   } state_t;

   state_t           state_q, state_d;
   logic [NBITS-1:0] tx_q, tx_d;
   logic [NBITS-1:0] rx_q, rx_d;
   logic [NBITS-1:0] rdata_q, rdata_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [DW-1:0]    div_q, div_d;
   logic             div_tc;

   assign div_tc = (div_q == '0);
   assign o_data = rdata_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         tx_q    <= '0;
         rx_q    <= '0;
         rdata_q <= '0;
         cnt_q   <= '0;
         div_q   <= '0;
      end else begin
         state_q <= state_d;
         tx_q    <= tx_d;
         rx_q    <= rx_d;
         rdata_q <= rdata_d;
         cnt_q   <= cnt_d;
         div_q   <= div_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      tx_d          = tx_q;
      rx_d          = rx_q;
      rdata_d       = rdata_q;
      cnt_d         = cnt_q;
      div_d         = div_q;
      o_busy        = 1'b0;
      o_done        = 1'b0;
      o_4094_clk    = 1'b0;
      o_4094_data   = 1'b0;
      o_4094_strobe = 1'b0;

      unique case (state_q)
         IDLE: ;
         LO: begin
            o_busy      = 1'b1;
            o_4094_data = tx_q[NBITS-1];
            if (div_tc) begin
               div_d   = DIV_LOAD;
               rx_d    = {rx_q[NBITS-2:0], i_4094_miso};
               state_d = HI;
            end else begin
               div_d = div_q - 1'b1;
            end
         end
         HI: begin
            o_busy      = 1'b1;
            o_4094_clk  = 1'b1;
            o_4094_data = tx_q[NBITS-1];
            if (div_tc) begin
               div_d = DIV_LOAD;
               cnt_d = cnt_q - 1'b1;
               if (cnt_q != CNT_ONE) begin
                  tx_d    = tx_q << 1;
                  state_d = LO;
               end else begin
                  state_d = STROBE;
               end
            end else begin
               div_d = div_q - 1'b1;
            end
         end
         STROBE: begin
            o_busy = 1'b1;
            // bit counter is 0 on entry and doubles as the settle-cycle flag
            if (cnt_q == '0) begin
               cnt_d = CNT_ONE;
               div_d = DIV_LOAD;
            end else begin
               o_4094_strobe = 1'b1;
               if (div_tc) begin
                  rdata_d = rx_q;
                  state_d = DONE;
               end else begin
                  div_d = div_q - 1'b1;
               end
            end
         end
         DONE: begin
            o_done  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      if (i_start && (state_q == IDLE || state_q == DONE)) begin
         tx_d    = i_data;
         cnt_d   = CNT_LOAD;
         div_d   = DIV_LOAD;
         state_d = LO;
      end
   end

endmodule

// File: tb/tb_spi_4094_master.sv
// Bench for spi_4094_master: three instances (8/2, 32/4, 8/1) each driving a
// behavioural 4094 chain; readback, latch and done cycle are checked via a scoreboard.
module tb_spi_4094_master;

   logic clk = 1'b0;
   logic reset_n = 1'b1;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int nvec = 0;
   int nerr = 0;

   // instance A: NBITS=8, CLK_DIV=2
   logic       a_start, a_busy, a_done, a_sck, a_mosi, a_stb, a_miso;
   logic [7:0] a_data, a_odata;
   // instance B: NBITS=32, CLK_DIV=4
   logic        b_start, b_busy, b_done, b_sck, b_mosi, b_stb, b_miso;
   logic [31:0] b_data, b_odata;
   // instance C: NBITS=8, CLK_DIV=1
   logic       c_start, c_busy, c_done, c_sck, c_mosi, c_stb, c_miso;
   logic [7:0] c_data, c_odata;

   spi_4094_master #(.NBITS(8), .CLK_DIV(2)) u_a (
      .clk(clk), .reset_n(reset_n), .i_start(a_start), .i_data(a_data),
      .o_busy(a_busy), .o_done(a_done), .o_data(a_odata), .o_4094_clk(a_sck),
      .o_4094_data(a_mosi), .o_4094_strobe(a_stb), .i_4094_miso(a_miso));

   spi_4094_master #(.NBITS(32), .CLK_DIV(4)) u_b (
      .clk(clk), .reset_n(reset_n), .i_start(b_start), .i_data(b_data),
      .o_busy(b_busy), .o_done(b_done), .o_data(b_odata), .o_4094_clk(b_sck),
      .o_4094_data(b_mosi), .o_4094_strobe(b_stb), .i_4094_miso(b_miso));

   spi_4094_master #(.NBITS(8), .CLK_DIV(1)) u_c (
      .clk(clk), .reset_n(reset_n), .i_start(c_start), .i_data(c_data),
      .o_busy(c_busy), .o_done(c_done), .o_data(c_odata), .o_4094_clk(c_sck),
      .o_4094_data(c_mosi), .o_4094_strobe(c_stb), .i_4094_miso(c_miso));

   // behavioural 4094 chains: shift on SCK rise, latch while STROBE high
   logic [7:0]  a_sr = '0, a_lat = '0;
   logic [31:0] b_sr = '0, b_lat = '0;
   logic [7:0]  c_sr = '0, c_lat = '0;
   assign a_miso = a_sr[7];
   assign b_miso = b_sr[31];
   assign c_miso = c_sr[7];
   always @(posedge a_sck) a_sr <= {a_sr[6:0], a_mosi};
   always @(posedge b_sck) b_sr <= {b_sr[30:0], b_mosi};
   always @(posedge c_sck) c_sr <= {c_sr[6:0], c_mosi};
   always @(posedge a_stb) a_lat <= a_sr;
   always @(posedge b_stb) b_lat <= b_sr;
   always @(posedge c_stb) c_lat <= c_sr;

   int         a_rises = 0, c_rises = 0, a_stb_rises = 0, a_stb_cyc = 0, viol = 0;
   logic [7:0] a_mosi_bits = '0;
   always @(posedge a_sck) begin
      a_rises++;
      a_mosi_bits = {a_mosi_bits[6:0], a_mosi};
   end
   always @(posedge c_sck) c_rises++;
   always @(posedge a_stb) a_stb_rises++;
   always @(negedge clk) begin
      if (a_stb) a_stb_cyc++;
      if ((a_sck && a_stb) || (b_sck && b_stb) || (c_sck && c_stb)) viol++;
   end

   typedef struct {
      logic [31:0] rd;
      logic [31:0] lat;
      int          done_at;
   } exp_t;
   exp_t sbq[$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wait_done(input int which, input int budget, output logic ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if ((which == 0 && a_done) || (which == 1 && b_done) || (which == 2 && c_done)) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic score(input string tag, input logic [31:0] rd, input logic [31:0] lat);
      exp_t e;
      nvec++;
      if (sbq.size() == 0) begin
         nerr++;
         $error("FAIL %s scoreboard: observed empty queue expected an entry", tag);
         return;
      end
      nvec--;
      e = sbq.pop_front();
      check({tag, " o_data"}, rd, e.rd);
      check({tag, " latch"}, lat, e.lat);
      check({tag, " done cycle"}, cyc, e.done_at);
   endtask

   initial begin
      logic ok;
      int   t, r0, s0;
      a_start = 1'b0; b_start = 1'b0; c_start = 1'b0;
      a_data = '0; b_data = '0; c_data = '0;

      // reset and idle
      reset_n = 1'b0;
      repeat (3) @(negedge clk);
      check("reset A outputs", 32'({a_busy, a_done, a_odata, a_sck, a_mosi, a_stb}), 32'h0);
      check("reset B outputs", 32'({b_busy, b_done, b_sck, b_mosi, b_stb}), 32'h0);
      check("reset B o_data", b_odata, 32'h0);
      check("reset C outputs", 32'({c_busy, c_done, c_odata, c_sck, c_mosi, c_stb}), 32'h0);
      reset_n = 1'b1;
      repeat (2) @(negedge clk);
      check("idle A busy", 32'(a_busy), 32'h0);

      // A: single transfer of A5, busy-time start pulse and data change ignored
      r0 = a_rises; s0 = a_stb_cyc;
      a_data = 8'hA5; a_start = 1'b1; t = cyc;
      sbq.push_back('{32'h0, 32'hA5, t + 1 + 35});
      @(negedge clk);
      a_start = 1'b0; a_data = 8'h00;
      check("A busy after accept", 32'(a_busy), 32'h1);
      repeat (8) @(negedge clk);
      a_start = 1'b1; a_data = 8'h3C;
      @(negedge clk);
      a_start = 1'b0;
      wait_done(0, 100, ok);
      check("A done seen", 32'(ok), 32'h1);
      check("A busy low in done", 32'(a_busy), 32'h0);
      score("A1", 32'(a_odata), 32'(a_lat));
      check("A sck rises", a_rises - r0, 32'd8);
      check("A mosi bits", 32'(a_mosi_bits), 32'hA5);
      check("A strobe cycles", a_stb_cyc - s0, 32'd2);
      repeat (40) @(negedge clk);
      check("A no extra transfer", a_rises - r0, 32'd8);
      check("A idle after", 32'(a_busy), 32'h0);

      // B: 32-bit readback of the previous write
      b_data = 32'hDEADBEEF; b_start = 1'b1; t = cyc;
      sbq.push_back('{32'h0, 32'hDEADBEEF, t + 1 + 2*32*4 + 4 + 1});
      @(negedge clk);
      b_start = 1'b0;
      wait_done(1, 400, ok);
      check("B1 done seen", 32'(ok), 32'h1);
      score("B1", b_odata, b_lat);
      @(negedge clk);
      b_data = 32'h12345678; b_start = 1'b1; t = cyc;
      sbq.push_back('{32'hDEADBEEF, 32'h12345678, t + 1 + 2*32*4 + 4 + 1});
      @(negedge clk);
      b_start = 1'b0;
      wait_done(1, 400, ok);
      check("B2 done seen", 32'(ok), 32'h1);
      score("B2", b_odata, b_lat);

      // C: CLK_DIV=1, start held high -> back-to-back transfers
      r0 = c_rises;
      c_data = 8'h5A; c_start = 1'b1; t = cyc;
      sbq.push_back('{32'h0, 32'h5A, t + 1 + 2*8 + 2});
      wait_done(2, 40, ok);
      check("C1 done seen", 32'(ok), 32'h1);
      check("C1 busy low in done", 32'(c_busy), 32'h0);
      score("C1", 32'(c_odata), 32'(c_lat));
      c_data = 8'hC3; t = cyc;
      sbq.push_back('{32'h5A, 32'hC3, t + 1 + 2*8 + 2});
      @(negedge clk);
      check("C2 LO after DONE", 32'({c_busy, c_done, c_sck, c_stb}), 32'b1000);
      wait_done(2, 40, ok);
      check("C2 done seen", 32'(ok), 32'h1);
      score("C2", 32'(c_odata), 32'(c_lat));
      c_data = 8'h0F; t = cyc;
      sbq.push_back('{32'hC3, 32'h0F, t + 1 + 2*8 + 2});
      @(negedge clk);
      check("C3 LO after DONE", 32'({c_busy, c_done, c_sck, c_stb}), 32'b1000);
      wait_done(2, 40, ok);
      check("C3 done seen", 32'(ok), 32'h1);
      score("C3", 32'(c_odata), 32'(c_lat));
      c_start = 1'b0;
      @(negedge clk);
      check("C idle after stop", 32'(c_busy), 32'h0);
      check("C sck rises", c_rises - r0, 32'd24);

      // A: reset during bit 5
      r0 = a_rises; s0 = a_stb_rises;
      a_data = 8'h0F; a_start = 1'b1;
      @(negedge clk);
      a_start = 1'b0;
      ok = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (a_rises - r0 >= 5) begin
            ok = 1'b1;
            break;
         end
      end
      check("A bit5 reached", 32'(ok), 32'h1);
      check("A sck high before reset", 32'({a_busy, a_sck}), 32'b11);
      #2 reset_n = 1'b0;
      #1;
      check("async reset A outputs", 32'({a_busy, a_done, a_odata, a_sck, a_mosi, a_stb}), 32'h0);
      check("async reset B o_data", b_odata, 32'h0);
      check("async reset C o_data", 32'(c_odata), 32'h0);
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      check("A no strobe after reset", a_stb_rises - s0, 32'd0);
      check("A latch kept", 32'(a_lat), 32'hA5);
      check("A chain after 5 shifts", 32'(a_sr), 32'hA1);
      a_data = 8'h66; a_start = 1'b1; t = cyc;
      sbq.push_back('{32'hA1, 32'h66, t + 1 + 35});
      @(negedge clk);
      a_start = 1'b0;
      wait_done(0, 100, ok);
      check("A post-reset done seen", 32'(ok), 32'h1);
      score("A post-reset", 32'(a_odata), 32'(a_lat));

      check("strobe never with sck high", viol, 32'd0);
      check("scoreboard drained", sbq.size(), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
